// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave register bank: N_RW control registers plus N_RO read-only status words.
// Define AXIL_REG_ALIGN_CHECK_EN to reject accesses whose addr[1:0] is non-zero with SLVERR.
module axil_reg_slave #(
    parameter int                  ADDR_W    = 40,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = 40'h00_A000_0000,
    parameter int                  N_RW      = 8,
    parameter int                  N_RO      = 4,
    parameter logic [N_RW*32-1:0]  RST_VAL   = '0
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    input  logic                                  s_awvalid,
    output logic                                  s_awready,
    input  logic [ADDR_W-1:0]                     s_awaddr,
    input  logic [2:0]                            s_awprot,
    input  logic                                  s_wvalid,
    output logic                                  s_wready,
    input  logic [31:0]                           s_wdata,
    input  logic [3:0]                            s_wstrb,
    output logic                                  s_bvalid,
    input  logic                                  s_bready,
    output logic [1:0]                            s_bresp,
    input  logic                                  s_arvalid,
    output logic                                  s_arready,
    input  logic [ADDR_W-1:0]                     s_araddr,
    input  logic [2:0]                            s_arprot,
    output logic                                  s_rvalid,
    input  logic                                  s_rready,
    output logic [31:0]                           s_rdata,
    output logic [1:0]                            s_rresp,
    output logic [N_RW*32-1:0]                    reg_q,
    output logic [N_RW-1:0]                       reg_wr_stb,
    input  logic [((N_RO > 0) ? N_RO : 1)*32-1:0] ro_d
);

    localparam int         DEC_W  = $clog2(N_RW + N_RO) + 2;
    localparam int         IDX_W  = (DEC_W > 2) ? DEC_W - 2 : 1;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
`ifdef AXIL_REG_ALIGN_CHECK_EN
    localparam bit         ALIGN_CHK = 1'b1;
`else
    localparam bit         ALIGN_CHK = 1'b0;
`endif

    // Word index inside the block window; a single-word bank has only index 0.
    function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] s;
        s     = a >> 2;
        f_idx = (DEC_W > 2) ? s[IDX_W-1:0] : '0;
    endfunction

    function automatic logic f_ok(input logic [ADDR_W-1:0] a);
        f_ok = ((a >> DEC_W) == (BASE_ADDR >> DEC_W)) && (!ALIGN_CHK || a[1:0] == 2'b00);
    endfunction

    logic [N_RW-1:0][31:0] r_regs;
    logic                  r_aw_held, r_w_held, r_bvalid;
    logic [ADDR_W-1:0]     r_aw_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic [1:0]            r_bresp;
    logic [N_RW-1:0]       r_wr_stb;
    logic                  r_rvalid;
    logic [31:0]           r_rdata;
    logic [1:0]            r_rresp;

    logic             w_commit, w_wr_rw;
    logic [IDX_W-1:0] w_wr_idx, w_ar_idx;
    logic             w_ar_ok, w_rd_err;
    logic [31:0]      w_rd_data;
    logic             w_unused;

    assign w_unused   = ^{s_awprot, s_arprot};

    assign s_awready  = !r_aw_held && !r_bvalid;
    assign s_wready   = !r_w_held && !r_bvalid;
    assign s_bvalid   = r_bvalid;
    assign s_bresp    = r_bresp;
    assign s_arready  = !r_rvalid;
    assign s_rvalid   = r_rvalid;
    assign s_rdata    = r_rdata;
    assign s_rresp    = r_rresp;
    assign reg_q      = r_regs;
    assign reg_wr_stb = r_wr_stb;

    assign w_commit = r_aw_held && r_w_held;
    assign w_wr_idx = f_idx(r_aw_addr);
    assign w_wr_rw  = f_ok(r_aw_addr) && (int'(w_wr_idx) < N_RW);

    // Write channel: AW and W park independently; the commit happens once both are present.
    // Strobe and new register value become visible together, alongside bvalid.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_regs    <= RST_VAL;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_addr <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= OKAY;
            r_wr_stb  <= '0;
        end else begin
            r_wr_stb <= '0;
            if (s_awvalid && s_awready) begin
                r_aw_held <= 1'b1;
                r_aw_addr <= s_awaddr;
            end
            if (s_wvalid && s_wready) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_wdata;
                r_wstrb  <= s_wstrb;
            end
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_rw ? OKAY : SLVERR;
                for (int i = 0; i < N_RW; i++) begin
                    if (w_wr_rw && int'(w_wr_idx) == i) begin
                        r_wr_stb[i] <= 1'b1;
                        for (int b = 0; b < 4; b++)
                            if (r_wstrb[b]) r_regs[i][8*b +: 8] <= r_wdata[8*b +: 8];
                    end
                end
            end else if (r_bvalid && s_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    assign w_ar_idx = f_idx(s_araddr);
    assign w_ar_ok  = f_ok(s_araddr);

    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b1;
        if (w_ar_ok) begin
            for (int i = 0; i < N_RW; i++) begin
                if (int'(w_ar_idx) == i) begin
                    w_rd_data = r_regs[i];
                    w_rd_err  = 1'b0;
                end
            end
            for (int j = 0; j < N_RO; j++) begin
                if (int'(w_ar_idx) == N_RW + j) begin
                    w_rd_data = ro_d[32*j +: 32];
                    w_rd_err  = 1'b0;
                end
            end
        end
    end

    // Read channel samples r_regs before any same-cycle commit lands, so it sees the old value.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= OKAY;
        end else if (s_arvalid && !r_rvalid) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_err ? SLVERR : OKAY;
        end else if (r_rvalid && s_rready) begin
            r_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Bench for axil_reg_slave: directed AXI-Lite traffic, a transaction-level register model
// and a per-cycle compare process. Honours AXIL_REG_ALIGN_CHECK_EN like the design.
module tb_axil_reg_slave;

    localparam int          N_RW = 8;
    localparam int          N_RO = 4;
    localparam logic [39:0] BASE = 40'h00_A000_0000;

    logic              aclk = 1'b0;
    logic              areset;
    logic              s_awvalid, s_awready, s_wvalid, s_wready;
    logic [39:0]       s_awaddr, s_araddr;
    logic [2:0]        s_awprot, s_arprot;
    logic [31:0]       s_wdata, s_rdata;
    logic [3:0]        s_wstrb;
    logic              s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]        s_bresp, s_rresp;
    logic [N_RW*32-1:0] reg_q;
    logic [N_RW-1:0]   reg_wr_stb;
    logic [N_RO*32-1:0] ro_d;

    int n_vec = 0;
    int n_err = 0;

    axil_reg_slave dut (
        .aclk(aclk), .areset(areset),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .reg_q(reg_q), .reg_wr_stb(reg_wr_stb), .ro_d(ro_d)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_regs [N_RW];
    logic [39:0] awq [$];
    logic [35:0] wq [$];
    logic [33:0] rq [$];
    logic [1:0]  exp_bresp;
    logic [33:0] exp_r;
    bit          prev_b, prev_bhs, prev_r, prev_rhs;

    // Word number of an address in the register map, or -1 when nothing answers there.
    function automatic int word_of(input logic [39:0] a);
        if (a < BASE || a >= BASE + 40'(4 * (N_RW + N_RO))) return -1;
`ifdef AXIL_REG_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) return -1;
`endif
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [N_RW*32-1:0] model_q();
        logic [N_RW*32-1:0] p;
        for (int i = 0; i < N_RW; i++) p[32*i +: 32] = m_regs[i];
        return p;
    endfunction

    always @(negedge aclk) begin
        logic [N_RW-1:0] exp_stb;
        logic [39:0]     a;
        logic [35:0]     wd;
        int              w;
        if (areset) begin
            for (int i = 0; i < N_RW; i++) m_regs[i] = 32'h0;
            awq.delete(); wq.delete(); rq.delete();
            prev_b = 0; prev_bhs = 0; prev_r = 0; prev_rhs = 0;
        end else begin
            exp_stb = '0;
            if (s_bvalid && (!prev_b || prev_bhs)) begin
                chk("b_has_request", (awq.size() > 0 && wq.size() > 0), 1);
                if (awq.size() > 0 && wq.size() > 0) begin
                    a  = awq.pop_front();
                    wd = wq.pop_front();
                    w  = word_of(a);
                    if (w >= 0 && w < N_RW) begin
                        exp_bresp = 2'b00;
                        exp_stb[w] = 1'b1;
                        for (int b = 0; b < 4; b++)
                            if (wd[32+b]) m_regs[w][8*b +: 8] = wd[8*b +: 8];
                    end else begin
                        exp_bresp = 2'b10;
                    end
                end
                chk("bresp", s_bresp, exp_bresp);
            end else if (s_bvalid) begin
                chk("bresp_hold", s_bresp, exp_bresp);
            end
            chk("reg_wr_stb", reg_wr_stb, exp_stb);
            chk("reg_q", reg_q, model_q());

            if (s_rvalid && (!prev_r || prev_rhs)) begin
                chk("r_has_request", rq.size() > 0, 1);
                if (rq.size() > 0) exp_r = rq.pop_front();
                chk("rdata", s_rdata, exp_r[31:0]);
                chk("rresp", s_rresp, exp_r[33:32]);
            end else if (s_rvalid) begin
                chk("rdata_hold", {s_rresp, s_rdata}, exp_r);
            end

            // Handshakes seen here complete at the coming posedge.
            if (s_awvalid && s_awready) awq.push_back(s_awaddr);
            if (s_wvalid && s_wready) wq.push_back({s_wstrb, s_wdata});
            if (s_arvalid && s_arready) begin
                w = word_of(s_araddr);
                if (w >= 0 && w < N_RW)             rq.push_back({2'b00, m_regs[w]});
                else if (w >= N_RW)                 rq.push_back({2'b00, ro_d[32*(w-N_RW) +: 32]});
                else                                rq.push_back({2'b10, 32'h0});
            end
            prev_b = s_bvalid;  prev_bhs = s_bvalid && s_bready;
            prev_r = s_rvalid;  prev_rhs = s_rvalid && s_rready;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input bit do_aw, input bit do_w, input logic [39:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        bit aw_hs, w_hs;
        int n = 0;
        s_awvalid = do_aw; s_awaddr = a; s_wvalid = do_w; s_wdata = d; s_wstrb = s;
        while ((s_awvalid || s_wvalid) && n < 50) begin
            @(negedge aclk);
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            @(posedge aclk); #1;
            if (aw_hs) s_awvalid = 1'b0;
            if (w_hs)  s_wvalid  = 1'b0;
            n++;
        end
        if (s_awvalid || s_wvalid) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: addr %0h not accepted within 50 cycles", a);
            s_awvalid = 1'b0; s_wvalid = 1'b0;
        end
    endtask

    task automatic wait_b(output int n, output logic [1:0] resp, output logic [N_RW-1:0] stb);
        bit found = 0;
        n = 0; resp = 2'bxx; stb = 'x;
        while (!found && n < 50) begin
            @(negedge aclk); n++;
            if (s_bvalid) begin found = 1; resp = s_bresp; stb = reg_wr_stb; end
        end
        @(posedge aclk); #1;
        if (!found) begin n_vec++; n_err++; $display("FAIL b_timeout: no bvalid in 50 cycles"); end
    endtask

    task automatic do_write(input logic [39:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] exp_resp, input logic [N_RW-1:0] exp_s);
        int n; logic [1:0] resp; logic [N_RW-1:0] stb;
        send(1, 1, a, d, s);
        wait_b(n, resp, stb);
        chk("wr_latency", n, 2);
        chk("wr_resp", resp, exp_resp);
        chk("wr_stb", stb, exp_s);
    endtask

    task automatic do_read(input logic [39:0] a, input logic [31:0] exp_d, input logic [1:0] exp_resp);
        int n = 0; bit found = 0; logic [31:0] d = 'x; logic [1:0] resp = 'x;
        s_arvalid = 1'b1; s_araddr = a;
        while (s_arvalid && n < 50) begin
            @(negedge aclk); found = s_arready;
            @(posedge aclk); #1;
            if (found) s_arvalid = 1'b0;
            n++;
        end
        n = 0; found = 0;
        while (!found && n < 50) begin
            @(negedge aclk); n++;
            if (s_rvalid) begin found = 1; d = s_rdata; resp = s_rresp; end
        end
        @(posedge aclk); #1;
        chk("rd_latency", n, 1);
        chk("rd_data", d, exp_d);
        chk("rd_resp", resp, exp_resp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n; logic [1:0] resp; logic [N_RW-1:0] stb;
        areset = 1'b1;
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_awaddr = '0; s_araddr = '0;
        s_awprot = '0; s_arprot = '0; s_wdata = '0; s_wstrb = '0;
        s_bready = 1'b1; s_rready = 1'b1;
        ro_d = {32'h4444_0003, 32'h3333_0002, 32'hBEEF_0002, 32'hCAFE_0001};
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;

        @(negedge aclk);
        chk("rst_awready", s_awready, 1); chk("rst_wready", s_wready, 1);
        chk("rst_arready", s_arready, 1); chk("rst_bvalid", s_bvalid, 0);
        chk("rst_rvalid", s_rvalid, 0);   chk("rst_bresp", s_bresp, 0);
        chk("rst_rresp", s_rresp, 0);     chk("rst_rdata", s_rdata, 0);
        chk("rst_stb", reg_wr_stb, 0);    chk("rst_reg_q", reg_q, 0);
        @(posedge aclk); #1;

        // AW+W together
        do_write(BASE + 40'h04, 32'hDEAD_BEEF, 4'hF, 2'b00, 8'b0000_0010);
        chk("reg1_full", reg_q[63:32], 32'hDEAD_BEEF);

        // W first, AW three cycles later, partial strobes
        send(0, 1, 40'h0, 32'h1234_5678, 4'b0101);
        repeat (3) begin
            @(negedge aclk);
            chk("w_held_wready", s_wready, 0);
            chk("w_held_awready", s_awready, 1);
            @(posedge aclk); #1;
        end
        send(1, 0, BASE + 40'h04, 32'h0, 4'h0);
        wait_b(n, resp, stb);
        chk("wfirst_latency", n, 2);
        chk("wfirst_resp", resp, 2'b00);
        chk("reg1_partial", reg_q[63:32], 32'hDE34_BE78);

        do_write(BASE + 40'h00, 32'h0000_00A5, 4'hF, 2'b00, 8'b0000_0001);
        do_write(BASE + 40'h08, 32'hFFFF_FFFF, 4'h0, 2'b00, 8'b0000_0100);
        chk("reg2_nostrb", reg_q[95:64], 32'h0);

        // RO words and unmapped space
        do_read(BASE + 40'h20, 32'hCAFE_0001, 2'b00);
        do_read(BASE + 40'h2C, 32'h4444_0003, 2'b00);
        do_read(BASE + 40'h1C, 32'h0, 2'b00);
        do_write(BASE + 40'h20, 32'h5555_5555, 4'hF, 2'b10, 8'h00);
        chk("reg1_after_ro_wr", reg_q[63:32], 32'hDE34_BE78);
        do_read(BASE + 40'h40, 32'h0, 2'b10);
        do_read(BASE + 40'h3C, 32'h0, 2'b10);
        do_write(BASE + 40'h3C, 32'h5555_5555, 4'hF, 2'b10, 8'h00);

        // Held B response back-pressures both write channels
        s_bready = 1'b0;
        send(1, 1, BASE + 40'h1C, 32'h7777_0007, 4'hF);
        wait_b(n, resp, stb);
        chk("stall_resp", resp, 2'b00);
        s_awvalid = 1'b1; s_awaddr = BASE + 40'h18; s_wvalid = 1'b1;
        s_wdata = 32'h6666_0006; s_wstrb = 4'hF;
        repeat (10) begin
            @(negedge aclk);
            chk("stall_bvalid", s_bvalid, 1);
            chk("stall_awready", s_awready, 0);
            chk("stall_wready", s_wready, 0);
            @(posedge aclk); #1;
        end
        s_bready = 1'b1;
        send(1, 1, BASE + 40'h18, 32'h6666_0006, 4'hF);
        wait_b(n, resp, stb);
        chk("after_stall_resp", resp, 2'b00);
        chk("reg7", reg_q[255:224], 32'h7777_0007);
        chk("reg6", reg_q[223:192], 32'h6666_0006);

        // Read issued in the commit cycle of a write to the same register sees the old value
        s_awvalid = 1'b1; s_awaddr = BASE + 40'h0C; s_wvalid = 1'b1;
        s_wdata = 32'h3333_0003; s_wstrb = 4'hF;
        @(posedge aclk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_arvalid = 1'b1; s_araddr = BASE + 40'h0C;
        @(posedge aclk); #1;
        s_arvalid = 1'b0;
        @(negedge aclk);
        chk("rw_race_rvalid", s_rvalid, 1);
        chk("rw_race_rdata", s_rdata, 32'h0);
        chk("rw_race_bvalid", s_bvalid, 1);
        @(posedge aclk); #1;
        do_read(BASE + 40'h0C, 32'h3333_0003, 2'b00);

        // Misaligned accesses
`ifdef AXIL_REG_ALIGN_CHECK_EN
        do_read(BASE + 40'h02, 32'h0, 2'b10);
        do_write(BASE + 40'h01, 32'hFFFF_FFFF, 4'hF, 2'b10, 8'h00);
        chk("reg0_misaligned", reg_q[31:0], 32'h0000_00A5);
`else
        do_read(BASE + 40'h02, 32'h0000_00A5, 2'b00);
        do_write(BASE + 40'h01, 32'hFFFF_FFFF, 4'hF, 2'b00, 8'h01);
        chk("reg0_misaligned", reg_q[31:0], 32'hFFFF_FFFF);
`endif

        // Reset in the middle of a write aborts it
        send(1, 0, BASE + 40'h10, 32'h0, 4'h0);
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        chk("midrst_awready", s_awready, 1);
        chk("midrst_wready", s_wready, 1);
        chk("midrst_bvalid", s_bvalid, 0);
        chk("midrst_reg_q", reg_q, 0);
        @(posedge aclk); #1;
        do_write(BASE + 40'h10, 32'hABCD_0010, 4'hF, 2'b00, 8'b0001_0000);
        do_read(BASE + 40'h10, 32'hABCD_0010, 2'b00);

        repeat (3) @(posedge aclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
